// File: rtl/aesl_deadlock_report_ctrl.sv
// Sink of the deadlock-token protocol: confirms a stable returned token, elects a
// single origin process and either declares the deadlock or flushes a spurious search.
module aesl_deadlock_report_ctrl #(
  parameter int PROC_NUM       = 3,
  parameter int IDX_W          = 2,
  parameter int CONFIRM_CYCLES = 4,
  parameter int CLEAR_CYCLES   = 2
) (
  input  logic                dl_clock,
  input  logic                dl_reset,
  input  logic [PROC_NUM-1:0] dl_in_vec,
  input  logic                ap_done_reg_0,
  output logic                dl_detect_out,
  output logic [PROC_NUM-1:0] origin,
  output logic                token_clear,
  output logic                dl_report_valid,
  output logic [IDX_W-1:0]    dl_report_proc,
  output logic [31:0]         dl_detect_cycle
);

  localparam int CNT_W = (CONFIRM_CYCLES > 1) ? $clog2(CONFIRM_CYCLES) : 1;
  localparam int CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CONFIRM_LAST = CNT_W'(CONFIRM_CYCLES - 1);
  localparam logic [CLR_W-1:0] CLEAR_LAST   = CLR_W'(CLEAR_CYCLES - 1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_CONFIRM  = 2'd1;
  localparam logic [1:0] S_CLEAR    = 2'd2;
  localparam logic [1:0] S_DETECTED = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [IDX_W-1:0]    cand_q, cand_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CLR_W-1:0]    clrCnt_q, clrCnt_d;
  logic [31:0]         cycle_q, cycle_d;
  logic                detect_q, detect_d;
  logic [PROC_NUM-1:0] origin_q, origin_d;
  logic                tokenClear_q, tokenClear_d;
  logic                valid_q, valid_d;
  logic [IDX_W-1:0]    proc_q, proc_d;
  logic [31:0]         detectCycle_q, detectCycle_d;

  logic [IDX_W-1:0]    lowIdx;
  logic                candBit;
  logic [PROC_NUM-1:0] candOneHot;

  // Priority pick of the lowest set index, plus decode of the candidate bit/one-hot.
  always_comb begin
    lowIdx     = '0;
    candBit    = 1'b0;
    candOneHot = '0;
    for (int i = PROC_NUM - 1; i >= 0; i--) begin
      if (dl_in_vec[i]) lowIdx = IDX_W'(i);
    end
    for (int i = 0; i < PROC_NUM; i++) begin
      if (IDX_W'(i) == cand_q) candBit = dl_in_vec[i];
      if (IDX_W'(i) == cand_d) candOneHot[i] = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    clrCnt_d = clrCnt_q;
    case (state_q)
      S_IDLE: begin
        if ((|dl_in_vec) && !ap_done_reg_0) begin
          cand_d  = lowIdx;
          cnt_d   = CNT_W'(1);
          state_d = (CONFIRM_CYCLES == 1) ? S_DETECTED : S_CONFIRM;
        end
      end
      S_CONFIRM: begin
        if (!candBit || ap_done_reg_0) begin
          state_d  = S_CLEAR;
          clrCnt_d = '0;
        end else if (cnt_q == CONFIRM_LAST) begin
          state_d = S_DETECTED;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CLEAR: begin
        if (clrCnt_q == CLEAR_LAST) state_d = S_IDLE;
        else                        clrCnt_d = clrCnt_q + 1'b1;
      end
      default: ;
    endcase
  end

  // Outputs are registered, so they are derived from the next state.
  always_comb begin
    cycle_d       = (&cycle_q) ? cycle_q : cycle_q + 32'd1;
    detect_d      = (state_d == S_DETECTED);
    valid_d       = (state_d == S_DETECTED) && (state_q != S_DETECTED);
    tokenClear_d  = (state_d == S_CLEAR);
    origin_d      = ((state_d == S_CONFIRM) || (state_d == S_DETECTED)) ? candOneHot : '0;
    proc_d        = valid_d ? cand_d : proc_q;
    detectCycle_d = valid_d ? cycle_q : detectCycle_q;
  end

  always_ff @(posedge dl_clock or negedge dl_reset) begin
    if (!dl_reset) begin
      state_q       <= S_IDLE;
      cand_q        <= '0;
      cnt_q         <= '0;
      clrCnt_q      <= '0;
      cycle_q       <= '0;
      detect_q      <= 1'b0;
      origin_q      <= '0;
      tokenClear_q  <= 1'b0;
      valid_q       <= 1'b0;
      proc_q        <= '0;
      detectCycle_q <= '0;
    end else begin
      state_q       <= state_d;
      cand_q        <= cand_d;
      cnt_q         <= cnt_d;
      clrCnt_q      <= clrCnt_d;
      cycle_q       <= cycle_d;
      detect_q      <= detect_d;
      origin_q      <= origin_d;
      tokenClear_q  <= tokenClear_d;
      valid_q       <= valid_d;
      proc_q        <= proc_d;
      detectCycle_q <= detectCycle_d;
    end
  end

  assign dl_detect_out   = detect_q;
  assign origin          = origin_q;
  assign token_clear     = tokenClear_q;
  assign dl_report_valid = valid_q;
  assign dl_report_proc  = proc_q;
  assign dl_detect_cycle = detectCycle_q;

endmodule

// File: tb/tb_aesl_deadlock_report_ctrl.sv
// Directed bench for aesl_deadlock_report_ctrl: default instance plus a
// CONFIRM_CYCLES=1 / PROC_NUM=2 instance for the edge-parameter case.
module tb_aesl_deadlock_report_ctrl;

  logic        dlClock = 1'b0;
  logic        dlReset;
  logic [2:0]  dlInVec;
  logic        apDone;
  logic        detect;
  logic [2:0]  origin;
  logic        tokenClear;
  logic        reportValid;
  logic [1:0]  reportProc;
  logic [31:0] detectCycle;

  logic [1:0]  dlInVec1;
  logic        apDone1;
  logic        detect1;
  logic [1:0]  origin1;
  logic        tokenClear1;
  logic        reportValid1;
  logic        reportProc1;
  logic [31:0] detectCycle1;

  int compareCount = 0;
  int failCount    = 0;

  always #5 dlClock = ~dlClock;

  aesl_deadlock_report_ctrl #(
    .PROC_NUM(3), .IDX_W(2), .CONFIRM_CYCLES(4), .CLEAR_CYCLES(2)
  ) dut (
    .dl_clock(dlClock), .dl_reset(dlReset), .dl_in_vec(dlInVec),
    .ap_done_reg_0(apDone), .dl_detect_out(detect), .origin(origin),
    .token_clear(tokenClear), .dl_report_valid(reportValid),
    .dl_report_proc(reportProc), .dl_detect_cycle(detectCycle)
  );

  aesl_deadlock_report_ctrl #(
    .PROC_NUM(2), .IDX_W(1), .CONFIRM_CYCLES(1), .CLEAR_CYCLES(2)
  ) dutEdge (
    .dl_clock(dlClock), .dl_reset(dlReset), .dl_in_vec(dlInVec1),
    .ap_done_reg_0(apDone1), .dl_detect_out(detect1), .origin(origin1),
    .token_clear(tokenClear1), .dl_report_valid(reportValid1),
    .dl_report_proc(reportProc1), .dl_detect_cycle(detectCycle1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compareCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge dlClock);
    #1;
  endtask

  // Called just after an edge; releases reset on the following falling edge.
  task automatic applyStimulus();
    dlReset = 1'b0;
    #4;
    dlReset = 1'b1;
  endtask

  initial begin
    dlReset  = 1'b0;
    dlInVec  = '0;
    apDone   = 1'b0;
    dlInVec1 = '0;
    apDone1  = 1'b0;
    #1;
    checkOutput("rst_detect", 32'(detect), 32'd0);
    checkOutput("rst_origin", 32'(origin), 32'd0);
    checkOutput("rst_clear", 32'(tokenClear), 32'd0);
    checkOutput("rst_valid", 32'(reportValid), 32'd0);
    checkOutput("rst_cycle", detectCycle, 32'd0);
    checkOutput("rst_edge_detect", 32'(detect1), 32'd0);

    tick();
    applyStimulus();

    // Single source, stable from cycle 10
    repeat (10) tick();
    dlInVec = 3'b100;
    tick();
    checkOutput("single_tent_origin", 32'(origin), 32'd4);
    checkOutput("single_tent_detect", 32'(detect), 32'd0);
    tick();
    tick();
    checkOutput("single_pre_detect", 32'(detect), 32'd0);
    tick();
    checkOutput("single_detect", 32'(detect), 32'd1);
    checkOutput("single_valid", 32'(reportValid), 32'd1);
    checkOutput("single_proc", 32'(reportProc), 32'd2);
    checkOutput("single_cycle", detectCycle, 32'd13);
    checkOutput("single_origin", 32'(origin), 32'd4);
    for (int i = 0; i < 20; i++) begin
      dlInVec = 3'(i);
      apDone  = i[0];
      tick();
    end
    checkOutput("hold_detect", 32'(detect), 32'd1);
    checkOutput("hold_valid", 32'(reportValid), 32'd0);
    checkOutput("hold_origin", 32'(origin), 32'd4);
    checkOutput("hold_proc", 32'(reportProc), 32'd2);
    checkOutput("hold_cycle", detectCycle, 32'd13);
    checkOutput("hold_clear", 32'(tokenClear), 32'd0);

    // Async reset mid-cycle while DETECTED
    #3;
    dlReset = 1'b0;
    #1;
    checkOutput("async_detect", 32'(detect), 32'd0);
    checkOutput("async_origin", 32'(origin), 32'd0);
    checkOutput("async_cycle", detectCycle, 32'd0);
    checkOutput("async_proc", 32'(reportProc), 32'd0);
    dlReset = 1'b1;
    dlInVec = 3'b010;
    apDone  = 1'b0;
    tick();
    checkOutput("restart_origin", 32'(origin), 32'd2);
    tick();
    tick();
    tick();
    checkOutput("restart_detect", 32'(detect), 32'd1);
    checkOutput("restart_proc", 32'(reportProc), 32'd1);
    checkOutput("restart_cycle", detectCycle, 32'd3);

    // Tie-break: lowest index wins, other bits ignored in CONFIRM
    tick();
    applyStimulus();
    dlInVec = 3'b110;
    tick();
    checkOutput("tie_origin", 32'(origin), 32'd2);
    dlInVec = 3'b010;
    tick();
    tick();
    tick();
    checkOutput("tie_detect", 32'(detect), 32'd1);
    checkOutput("tie_proc", 32'(reportProc), 32'd1);
    checkOutput("tie_origin_final", 32'(origin), 32'd2);
    checkOutput("tie_cycle", detectCycle, 32'd3);

    // Glitch: two cycles then drop -> CLEAR for two cycles
    tick();
    applyStimulus();
    dlInVec = 3'b001;
    tick();
    checkOutput("glitch_origin1", 32'(origin), 32'd1);
    tick();
    checkOutput("glitch_origin2", 32'(origin), 32'd1);
    dlInVec = 3'b000;
    tick();
    checkOutput("glitch_clear1", 32'(tokenClear), 32'd1);
    checkOutput("glitch_clear1_origin", 32'(origin), 32'd0);
    checkOutput("glitch_clear1_detect", 32'(detect), 32'd0);
    dlInVec = 3'b001;
    tick();
    checkOutput("glitch_clear2", 32'(tokenClear), 32'd1);
    checkOutput("glitch_clear2_origin", 32'(origin), 32'd0);
    tick();
    checkOutput("glitch_idle_clear", 32'(tokenClear), 32'd0);
    checkOutput("glitch_idle_origin", 32'(origin), 32'd0);
    tick();
    checkOutput("glitch_reelect", 32'(origin), 32'd1);
    tick();
    tick();
    checkOutput("glitch_pre_detect", 32'(detect), 32'd0);
    tick();
    checkOutput("glitch_detect", 32'(detect), 32'd1);
    checkOutput("glitch_proc", 32'(reportProc), 32'd0);
    checkOutput("glitch_cycle", detectCycle, 32'd8);

    // Done suppression in IDLE, then done rising during CONFIRM
    tick();
    applyStimulus();
    apDone  = 1'b1;
    dlInVec = 3'b011;
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("done_idle", {27'd0, detect, tokenClear, reportValid, origin}, 32'd0);
    end
    apDone = 1'b0;
    tick();
    checkOutput("done_confirm_origin", 32'(origin), 32'd1);
    apDone = 1'b1;
    tick();
    checkOutput("done_clear1", 32'(tokenClear), 32'd1);
    checkOutput("done_clear1_origin", 32'(origin), 32'd0);
    apDone = 1'b0;
    tick();
    checkOutput("done_clear2", 32'(tokenClear), 32'd1);
    tick();
    checkOutput("done_idle_clear", 32'(tokenClear), 32'd0);
    checkOutput("done_no_detect", 32'(detect), 32'd0);
    tick();
    checkOutput("done_reelect", 32'(origin), 32'd1);

    // Edge parameters: CONFIRM_CYCLES=1, PROC_NUM=2
    tick();
    applyStimulus();
    dlInVec  = 3'b000;
    dlInVec1 = 2'b10;
    tick();
    checkOutput("edge_detect", 32'(detect1), 32'd1);
    checkOutput("edge_valid", 32'(reportValid1), 32'd1);
    checkOutput("edge_proc", 32'(reportProc1), 32'd1);
    checkOutput("edge_origin", 32'(origin1), 32'd2);
    checkOutput("edge_cycle", detectCycle1, 32'd0);
    tick();
    checkOutput("edge_valid_pulse", 32'(reportValid1), 32'd0);
    checkOutput("edge_detect_hold", 32'(detect1), 32'd1);
    checkOutput("edge_clear", 32'(tokenClear1), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
